// File: rtl/ni_read_request_unit_if.sv
// Bus bundle between the leaf router / PE controller side and the NI read request unit.
// Signal names follow the NI port list; modport direction gives the i/o sense.
interface ni_read_request_unit_if #(
    parameter int ACT_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH      = 3
);
    logic                      rqst_valid;
    logic [ACT_ADDR_WIDTH-1:0] rqst_addr;
    logic                      rqst_credit;
    logic                      act_send_en;
    logic                      fin_comp;
    logic                      router_rdy;
    logic                      read_rqst_read_en;
    logic                      act_read_en;
    logic [ACT_ADDR_WIDTH-1:0] act_read_addr;
    logic                      ni_read_rqst;
    logic [ACT_ADDR_WIDTH-1:0] ni_read_addr;
    logic [CNT_WIDTH-1:0]      fifo_count;
    logic                      overflow_err;

    modport slave (
        input  rqst_valid, rqst_addr, act_send_en, fin_comp, router_rdy,
        output rqst_credit, read_rqst_read_en, act_read_en, act_read_addr,
               ni_read_rqst, ni_read_addr, fifo_count, overflow_err
    );

    modport master (
        output rqst_valid, rqst_addr, act_send_en, fin_comp, router_rdy,
        input  rqst_credit, read_rqst_read_en, act_read_en, act_read_addr,
               ni_read_rqst, ni_read_addr, fifo_count, overflow_err
    );
endinterface

// File: rtl/ni_read_request_unit.sv
// Buffers READ requests from the leaf router, reads the activation register file and
// presents the READ to the NI output stage one cycle later, when the data is valid.
module ni_read_request_unit #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ACT_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    ni_read_request_unit_if.slave  bus
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, PEND} state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [ACT_ADDR_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]      r_head;
    logic [PTR_WIDTH-1:0]      r_tail;
    logic [CNT_WIDTH-1:0]      r_count;
    logic [ACT_ADDR_WIDTH-1:0] r_niReadAddr;
    logic                      r_overflow;
    logic                      w_accept;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_push;
    logic                      w_actReadEn;
    logic [ACT_ADDR_WIDTH-1:0] w_actReadAddr;

    // A pop is only allowed when the output stage will also consume this cycle,
    // so its credit counter never sees two decrements at once.
    assign w_accept = !bus.act_send_en && !bus.fin_comp;
    assign w_pop    = (r_count != '0) && bus.router_rdy && w_accept;
    assign w_full   = (r_count == CNT_WIDTH'(FIFO_DEPTH));
    assign w_push   = bus.rqst_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= bus.rqst_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (bus.rqst_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_niReadAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_pop) begin
                r_niReadAddr <= r_mem[r_head];
            end
        end
    end

    // While a READ is stalled the register file is re-read every cycle so its
    // output stays aligned with the held request.
    always_comb begin
        w_nextState   = r_state;
        w_actReadEn   = 1'b0;
        w_actReadAddr = '0;
        if (w_pop) begin
            w_actReadEn   = 1'b1;
            w_actReadAddr = r_mem[r_head];
        end else if (r_state == PEND && !w_accept) begin
            w_actReadEn   = 1'b1;
            w_actReadAddr = r_niReadAddr;
        end
        case (r_state)
            IDLE:    if (w_pop) w_nextState = PEND;
            PEND:    if (w_accept) w_nextState = w_pop ? PEND : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign bus.rqst_credit       = w_pop;
    assign bus.read_rqst_read_en = w_pop;
    assign bus.act_read_en       = w_actReadEn;
    assign bus.act_read_addr     = w_actReadAddr;
    assign bus.ni_read_rqst      = (r_state == PEND);
    assign bus.ni_read_addr      = r_niReadAddr;
    assign bus.fifo_count        = r_count;
    assign bus.overflow_err      = r_overflow;
endmodule

// File: doc/ni_read_request_unit.md
Name: ni_read_request_unit

Overview:
- Buffers READ requests arriving from the leaf router at the PE network interface.
- Issues the synchronous read to the output-activation register file.
- Hands the address to the NI output stage as `ni_read_rqst` / `ni_read_addr`, timed so that the register-file data is valid in the same cycle.
- Arbitrates against activation broadcast and FIN_COMP traffic, and obeys the output stage's credit-based `router_rdy` flow control.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, at least 2.
- ACT_ADDR_WIDTH, 6, activation index width.
- CNT_WIDTH, 3, occupancy counter width; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- rqst_valid  input  1  READ request from router, one per cycle
- rqst_addr  input  ACT_ADDR_WIDTH  requested activation index
- rqst_credit  output  1  one-cycle pulse returning one FIFO credit upstream
- act_send_en  input  1  PE controller broadcast this cycle
- fin_comp  input  1  PE controller FIN_COMP this cycle
- router_rdy  input  1  output stage holds at least 1 downstream credit
- read_rqst_read_en  output  1  FIFO pop and credit-consume strobe
- act_read_en  output  1  register-file read enable; data valid next cycle
- act_read_addr  output  ACT_ADDR_WIDTH  register-file read address
- ni_read_rqst  output  1  READ packet request to output stage
- ni_read_addr  output  ACT_ADDR_WIDTH  address embedded in READ packet
- fifo_count  output  CNT_WIDTH  current occupancy
- overflow_err  output  1  sticky: push into full FIFO

Behaviour:
- Reset: FIFO empty and pointers 0. `fifo_count`=0, `ni_read_rqst`=0, `ni_read_addr`=0, `overflow_err`=0. All combinational outputs are 0.
- Push:
  - `rqst_valid` writes `rqst_addr` at the tail.
  - Push into a full FIFO is dropped, with no pointer change; it sets `overflow_err` until reset.
  - Simultaneous push and pop while full is legal: the pop frees the slot first, so the push is not an overflow.
- Definitions:
  - `accept` = !act_send_en & !fin_comp. When `accept` is high, the output stage consumes `ni_read_rqst` this cycle.
  - `pop` = (`fifo_count`!=0) & `router_rdy` & `accept`. Combinational; drives `read_rqst_read_en`.
  - A pop is never issued in a cycle with `act_send_en` or `fin_comp`. This keeps the output stage's credit counter at a single decrement per cycle.
- Pop cycle N:
  - `read_rqst_read_en`=1, `rqst_credit`=1.
  - `act_read_en`=1, `act_read_addr`=head entry.
  - Head pointer advances, wrapping modulo FIFO_DEPTH.
- Cycle N+1: `ni_read_rqst`=1 (registered) and `ni_read_addr`=popped address. Register-file data is valid this cycle.
- Pending state (PEND), `ni_read_rqst`=1:
  - If `accept`=1: the request is consumed. The next state is PEND again if `pop` occurs this cycle (back-to-back, one READ per cycle), otherwise IDLE.
  - If `accept`=0: hold `ni_read_rqst` and `ni_read_addr`. Re-assert `act_read_en` with `act_read_addr`=`ni_read_addr`, so the register-file data is valid again in the following cycle. No pop occurs.
- `act_read_addr` mux: head entry when `pop`, else `ni_read_addr` when in PEND with `accept`=0, else 0.
- `fifo_count`: +1 on accepted push, -1 on pop, unchanged when both occur. It never wraps.
- Credits: upstream credits equal FIFO_DEPTH at reset. The block never returns more than one credit per cycle.
- Reset mid-operation: pending request and FIFO contents are discarded. Upstream credit resynchronisation is handled by the system-level reset.

Test Plan:
- Single request, idle controller:
  - Stimulus: push addr 6'h15 at cycle 0; `router_rdy`=1.
  - Required: `read_rqst_read_en`, `act_read_en`, `act_read_addr`=0x15 and `rqst_credit` at cycle 1. `ni_read_rqst`=1 with `ni_read_addr`=0x15 at cycle 2, for 1 cycle. `fifo_count` returns to 0.
- Back-to-back:
  - Stimulus: push 0x01, 0x02, 0x03 on consecutive cycles.
  - Required: three consecutive pops, then `ni_read_rqst` high for 3 consecutive cycles with addresses 0x01, 0x02, 0x03 in order.
- Broadcast collision:
  - Stimulus: one entry pending (`ni_read_rqst`=1, addr 0x2A); `act_send_en` held high for 2 cycles.
  - Required: `ni_read_rqst` holds 0x2A for both cycles with `act_read_en`=1, `act_read_addr`=0x2A, and `read_rqst_read_en`=0. The request is released on the third cycle.
- No credit:
  - Stimulus: `router_rdy`=0 with 3 entries queued.
  - Required: no pop and `fifo_count`=3 held. On `router_rdy`=1, pops resume in FIFO order.
- Overflow and wrap:
  - Stimulus: 5 pushes with `router_rdy`=0.
  - Required: `fifo_count`=4 and `overflow_err`=1 (sticky). After draining, 6 more push/pop pairs complete with correct order across the pointer wrap.
- Async reset:
  - Stimulus: assert `rst` mid-burst while in PEND.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge. `overflow_err` clears.
